// File: rtl/calc_entry_sequencer.sv
// Keypad calculator entry sequencer: collects operands and operator from key events,
// issues one ALU request per '=', and produces the registered display value.
module calc_entry_sequencer #(
   parameter int DIGITS  = 4,
   parameter int W       = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   input  logic [3:0]   key_code,
   output logic         key_ready,
   output logic         alu_start,
   output logic [1:0]   alu_op,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic         alu_done,
   input  logic         alu_err,
   input  logic [W-1:0] alu_result,
   output logic [W-1:0] disp_value,
   output logic         error
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {ENTER_A, ENTER_B, CALC, SHOW, ERR} state_t;

   state_t         state;
   logic [W-1:0]   opa;
   logic [W-1:0]   opb;
   logic [1:0]     op;
   logic [CW-1:0]  cnt;
   logic [TW-1:0]  tcnt;

   logic       key_accept;
   logic       is_digit;
   logic       is_op;
   logic       is_eq;
   logic       is_clr;
   logic       room;
   logic       timeout_hit;
   logic [1:0] op_code;

   // key_ready is a register that always equals (state != CALC), so it gates keys directly.
   assign key_accept  = key_valid & key_ready;
   assign is_digit    = (key_code <= 4'd9);
   assign is_op       = (key_code >= 4'hA) && (key_code <= 4'hD);
   assign is_eq       = (key_code == 4'hE);
   assign is_clr      = (key_code == 4'hF);
   assign room        = (cnt < CW'(DIGITS));
   assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));
   // Keys A,B,C,D select add,sub,mul,div, i.e. ALU codes 00,01,10,11.
   assign op_code     = {~key_code[1], key_code[0]};

   assign alu_a  = opa;
   assign alu_b  = opb;
   assign alu_op = op;

   // NOTE: every register here uses non-blocking assignment, so all right-hand sides
   // (including the display mux) see the values from before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ENTER_A;
         opa        <= '0;
         opb        <= '0;
         op         <= '0;
         cnt        <= '0;
         tcnt       <= '0;
         disp_value <= '0;
         alu_start  <= 1'b0;
         key_ready  <= 1'b1;
         error      <= 1'b0;
      end else begin
         alu_start <= 1'b0;

         // Display follows the state one cycle behind; CALC keeps the last shown value.
         case (state)
            ENTER_A, SHOW: disp_value <= opa;
            ENTER_B:       disp_value <= (cnt != '0) ? opb : opa;
            ERR:           disp_value <= '0;
            default:       ;
         endcase

         if (key_accept && is_clr) begin
            state      <= ENTER_A;
            opa        <= '0;
            opb        <= '0;
            op         <= '0;
            cnt        <= '0;
            tcnt       <= '0;
            disp_value <= '0;
            key_ready  <= 1'b1;
            error      <= 1'b0;
         end else begin
            case (state)
               ENTER_A: begin
                  if (key_accept) begin
                     if (is_digit && room) begin
                        opa <= {opa[W-5:0], key_code};
                        cnt <= cnt + 1'b1;
                     end else if (is_op) begin
                        op    <= op_code;
                        opb   <= '0;
                        cnt   <= '0;
                        state <= ENTER_B;
                     end
                  end
               end

               ENTER_B: begin
                  if (key_accept) begin
                     if (is_digit && room) begin
                        opb <= {opb[W-5:0], key_code};
                        cnt <= cnt + 1'b1;
                     end else if (is_op && cnt == '0) begin
                        op <= op_code;
                     end else if (is_eq && cnt != '0) begin
                        state     <= CALC;
                        alu_start <= 1'b1;
                        key_ready <= 1'b0;
                        tcnt      <= '0;
                     end
                  end
               end

               CALC: begin
                  // A done arriving in the timeout cycle still completes the request.
                  if (alu_done) begin
                     key_ready <= 1'b1;
                     if (alu_err) begin
                        state <= ERR;
                        error <= 1'b1;
                     end else begin
                        opa   <= alu_result;
                        cnt   <= '0;
                        state <= SHOW;
                     end
                  end else if (timeout_hit) begin
                     state     <= ERR;
                     error     <= 1'b1;
                     key_ready <= 1'b1;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end

               SHOW: begin
                  if (key_accept) begin
                     if (is_digit) begin
                        opa   <= W'(key_code);
                        cnt   <= CW'(1);
                        state <= ENTER_A;
                     end else if (is_op) begin
                        op    <= op_code;
                        opb   <= '0;
                        cnt   <= '0;
                        state <= ENTER_B;
                     end
                  end
               end

               ERR:     ;
               default: state <= ENTER_A;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Bench for calc_entry_sequencer: directed scenarios followed by random key/ALU traffic,
// all checked against a key-level behavioural model of the calculator.
module tb_calc_entry_sequencer;

   localparam int TIMEOUT = 64;
   localparam int M_A = 0, M_B = 1, M_CALC = 2, M_SHOW = 3, M_ERR = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_ready;
   logic        alu_start;
   logic [1:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_done;
   logic        alu_err;
   logic [15:0] alu_result;
   logic [15:0] disp_value;
   logic        error;

   int total = 0;
   int bad   = 0;
   int unsigned cyc = 0;

   int m_mode, m_a, m_b, m_op, m_n, m_disp;
   int unsigned calc_start;

   calc_entry_sequencer #(.DIGITS(4), .W(16), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ready  (key_ready),
      .alu_start  (alu_start),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_done   (alu_done),
      .alu_err    (alu_err),
      .alu_result (alu_result),
      .disp_value (disp_value),
      .error      (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_view();
      case (m_mode)
         M_A, M_SHOW: return m_a;
         M_B:         return (m_n > 0) ? m_b : m_a;
         M_ERR:       return 0;
         default:     return m_disp;
      endcase
   endfunction

   task automatic model_clear();
      m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_n = 0; m_disp = 0;
   endtask

   task automatic model_key(input int code);
      if (m_mode == M_CALC) return;
      if (code == 15) begin
         model_clear();
         return;
      end
      case (m_mode)
         M_A: begin
            if (code < 10) begin
               if (m_n < 4) begin m_a = (m_a * 16 + code) % 65536; m_n++; end
            end else if (code <= 13) begin
               m_op = code - 10; m_b = 0; m_n = 0; m_mode = M_B;
            end
         end
         M_B: begin
            if (code < 10) begin
               if (m_n < 4) begin m_b = (m_b * 16 + code) % 65536; m_n++; end
            end else if (code <= 13) begin
               if (m_n == 0) m_op = code - 10;
            end else if (code == 14 && m_n > 0) begin
               m_mode = M_CALC;
            end
         end
         M_SHOW: begin
            if (code < 10) begin
               m_a = code; m_n = 1; m_mode = M_A;
            end else if (code <= 13) begin
               m_op = code - 10; m_b = 0; m_n = 0; m_mode = M_B;
            end
         end
         default: ;
      endcase
   endtask

   // One key strobe, then one idle cycle so the display has caught up before checking.
   task automatic step_key(input int code);
      int prev;
      prev = m_mode;
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = code[3:0];
      @(negedge clk);
      key_valid = 1'b0;
      model_key(code);
      if (prev != M_CALC && m_mode == M_CALC) begin
         calc_start = cyc;
         check("start_pulse", alu_start, 1);
         check("req_a", alu_a, m_a);
         check("req_b", alu_b, m_b);
         check("req_op", alu_op, m_op);
      end else begin
         check("no_start", alu_start, 0);
      end
      @(negedge clk);
      if (m_mode != M_CALC) m_disp = model_view();
      check("disp", disp_value, m_disp);
      check("error", error, m_mode == M_ERR);
      check("key_ready", key_ready, m_mode != M_CALC);
   endtask

   // Answer the pending request after d idle cycles (or never, when send=0).
   // A done seen in CALC cycle c (first CALC cycle is 1) counts only if c <= TIMEOUT.
   task automatic alu_respond(input int d, input bit send, input bit err, input logic [15:0] res);
      int c;
      if (!send) d = TIMEOUT + 2;
      repeat (d) @(negedge clk);
      c = int'(cyc - calc_start) + 1;
      if (send) begin
         if (c <= TIMEOUT) begin
            check("hold_a", alu_a, m_a);
            check("hold_b", alu_b, m_b);
            check("hold_op", alu_op, m_op);
         end
         alu_done   = 1'b1;
         alu_err    = err;
         alu_result = res;
      end
      @(negedge clk);
      alu_done = 1'b0;
      alu_err  = 1'b0;
      if (send && c <= TIMEOUT) begin
         if (err) m_mode = M_ERR;
         else begin m_a = res; m_n = 0; m_mode = M_SHOW; end
      end else begin
         m_mode = M_ERR;
      end
      @(negedge clk);
      m_disp = model_view();
      check("resp_disp", disp_value, m_disp);
      check("resp_error", error, m_mode == M_ERR);
      check("resp_ready", key_ready, 1);
      check("resp_start", alu_start, 0);
      if (m_mode == M_SHOW) check("resp_a", alu_a, m_a);
   endtask

   initial begin
      int r, code;
      rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0;
      alu_done = 1'b0; alu_err = 1'b0; alu_result = 16'h0;
      model_clear();
      repeat (2) @(negedge clk);
      check("rst_disp", disp_value, 0);
      check("rst_ready", key_ready, 1);
      check("rst_error", error, 0);
      check("rst_start", alu_start, 0);
      check("rst_a", alu_a, 0);
      check("rst_op", alu_op, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 12 + 3 = 0x15
      step_key(1); step_key(2); step_key(10); step_key(3); step_key(14);
      check("t1_a", alu_a, 16'h0012);
      check("t1_b", alu_b, 16'h0003);
      check("t1_op", alu_op, 2'b00);
      alu_respond(3, 1, 0, 16'h0015);
      check("t1_disp", disp_value, 16'h0015);

      // Chain a subtraction onto the shown result
      step_key(11); step_key(5); step_key(14);
      check("t4_a", alu_a, 16'h0015);
      check("t4_b", alu_b, 16'h0005);
      check("t4_op", alu_op, 2'b01);
      alu_respond(1, 1, 0, 16'h0010);

      // Fifth digit is dropped
      step_key(15); step_key(1); step_key(2); step_key(3); step_key(4); step_key(5);
      check("t2_disp", disp_value, 16'h1234);

      // Divide by zero -> ERR, only F leaves it
      step_key(15); step_key(8); step_key(13); step_key(0); step_key(14);
      alu_respond(2, 1, 1, 16'hBEEF);
      check("t3_error", error, 1);
      check("t3_disp", disp_value, 0);
      step_key(5);
      check("t3_stuck", error, 1);
      step_key(15);
      check("t3_clr_err", error, 0);
      check("t3_clr_disp", disp_value, 0);

      // F dropped in CALC, then timeout
      step_key(7); step_key(10); step_key(1); step_key(14);
      step_key(15);
      check("t5_ready", key_ready, 0);
      alu_respond(0, 0, 0, 16'h0);
      check("t5_error", error, 1);
      step_key(15);

      // Done in the final timeout cycle wins; one cycle later it is too late
      step_key(2); step_key(10); step_key(3); step_key(14);
      alu_respond(TIMEOUT - 2, 1, 0, 16'h0005);
      check("edge_win", error, 0);
      step_key(15);
      step_key(2); step_key(10); step_key(3); step_key(14);
      alu_respond(TIMEOUT - 1, 1, 0, 16'h0005);
      check("edge_late", error, 1);
      step_key(15);

      // Reset mid-CALC abandons the request
      step_key(1); step_key(10); step_key(2); step_key(14);
      @(negedge clk);
      rst_n = 1'b0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      alu_done = 1'b1; alu_result = 16'h1234;
      @(negedge clk);
      alu_done = 1'b0;
      @(negedge clk);
      check("t6_disp", disp_value, 0);
      check("t6_error", error, 0);
      check("t6_ready", key_ready, 1);
      check("t6_a", alu_a, 0);
      check("t6_b", alu_b, 0);
      check("t6_op", alu_op, 0);
      check("t6_start", alu_start, 0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      code = $urandom_range(0, 9);
         else if (r < 75) code = $urandom_range(10, 13);
         else if (r < 95) code = 14;
         else             code = 15;
         step_key(code);
         if (m_mode == M_CALC) begin
            if ($urandom_range(0, 3) == 0) step_key($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0)
               alu_respond(0, 0, 0, 16'h0);
            else
               alu_respond($urandom_range(0, TIMEOUT + 3), 1, $urandom_range(0, 7) == 0,
                           16'($urandom));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
